// File: rtl/mod_alu_interface_if.sv
// Bus between the UART RX/TX pair, the ALU and the byte-stream front end.
// The slave modport is the front end; the master modport is the surrounding top level.
interface mod_alu_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_res;
    logic [NB_DATA-1:0] o_alu_data_A;
    logic [NB_DATA-1:0] o_alu_data_B;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_op_error;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_res,
        output o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data,
               o_tx_start, o_busy, o_op_error
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_res,
        input  o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data,
               o_tx_start, o_busy, o_op_error
    );
endinterface

// File: rtl/mod_alu_interface.sv
// Collects operand A, operand B and opcode bytes, drives the ALU and hands its result to the UART TX.
// Optional opcode validation is enabled with the ALUIF_OPCHECK_EN macro.
module mod_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    mod_alu_interface_if.slave   bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_TX   = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    state_t             state_q;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_OP-1:0]   op_d;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;

    // Only the low NB_OP bits of the opcode byte are meaningful to the ALU.
    assign op_d = bus.i_rx_data[NB_OP-1:0];

`ifdef ALUIF_OPCHECK_EN
    logic op_err_q;

    function automatic logic op_valid(input logic [NB_OP-1:0] op);
        case (op)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b000011, 6'b000010, 6'b100111: op_valid = 1'b1;
            default:                                    op_valid = 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef ALUIF_OPCHECK_EN
            op_err_q   <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef ALUIF_OPCHECK_EN
            op_err_q   <= 1'b0;
`endif
            case (state_q)
                S_A: if (bus.i_rx_done) begin
                    a_q     <= bus.i_rx_data;
                    state_q <= S_B;
                end
                S_B: if (bus.i_rx_done) begin
                    b_q     <= bus.i_rx_data;
                    state_q <= S_OP;
                end
                S_OP: if (bus.i_rx_done) begin
`ifdef ALUIF_OPCHECK_EN
                    // Rejected opcodes leave the previous opcode in place and restart collection.
                    if (op_valid(op_d)) begin
                        op_q    <= op_d;
                        state_q <= S_CALC;
                    end else begin
                        op_err_q <= 1'b1;
                        state_q  <= S_A;
                    end
`else
                    op_q    <= op_d;
                    state_q <= S_CALC;
`endif
                end
                // The ALU has had a full cycle to settle on the registered operands.
                S_CALC: begin
                    tx_data_q  <= bus.i_alu_res;
                    tx_start_q <= 1'b1;
                    state_q    <= S_TX;
                end
                S_TX:   state_q <= S_WAIT;
                S_WAIT: if (bus.i_tx_done) state_q <= S_A;
                default: state_q <= S_A;
            endcase
        end
    end

    assign bus.o_alu_data_A = a_q;
    assign bus.o_alu_data_B = b_q;
    assign bus.o_alu_op     = op_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_busy       = (state_q == S_CALC) || (state_q == S_TX) || (state_q == S_WAIT);
`ifdef ALUIF_OPCHECK_EN
    assign bus.o_op_error   = op_err_q;
`else
    assign bus.o_op_error   = 1'b0;
`endif

endmodule

// File: doc/mod_alu_interface.md
Name: mod_alu_interface

Overview:
- Byte-stream front end that feeds the combinational ALU and returns its result.
- Collects three bytes from the UART receiver, in order: operand A, operand B, opcode.
- Drives the ALU operand and opcode inputs, captures the ALU result one cycle later, and hands it to the UART transmitter with a start pulse.
- Sits between the UART RX/TX pair and the ALU in the top level.

Parameters:
- NB_DATA, 8, width of operands, result and UART bytes.
- NB_OP, 6, width of the ALU opcode.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_DATA  byte from the UART receiver; valid while i_rx_done is high.
- i_rx_done  in  1  one-cycle pulse, one per received byte.
- i_tx_done  in  1  one-cycle pulse from the UART transmitter when a byte has finished sending.
- i_alu_res  in  NB_DATA  ALU result (combinational from o_alu_data_A/B/o_alu_op).
- o_alu_data_A  out  NB_DATA  registered operand A to the ALU.
- o_alu_data_B  out  NB_DATA  registered operand B to the ALU.
- o_alu_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  registered result byte for the transmitter.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  out  1  high while a result is being computed or transmitted.
- o_op_error  out  1  one-cycle pulse on an invalid opcode (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: all outputs 0 and state S_A. Reset has priority over every other input in the same cycle.
- FSM states: S_A, S_B, S_OP, S_CALC, S_TX, S_WAIT.
- S_A: on i_rx_done, o_alu_data_A <= i_rx_data, go to S_B.
- S_B: on i_rx_done, o_alu_data_B <= i_rx_data, go to S_OP.
- S_OP: on i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0], go to S_CALC. Upper byte bits are ignored.
- S_CALC: lasts one cycle, during which the ALU settles. At the end of the cycle, o_tx_data <= i_alu_res and o_tx_start <= 1; go to S_TX.
- S_TX: o_tx_start is high for exactly this one cycle; it clears on the next edge. Go to S_WAIT.
- S_WAIT: on i_tx_done, go to S_A.
- Latency: op-byte i_rx_done in cycle n -> S_CALC in n+1 -> o_tx_start high in n+2, with o_tx_data valid in n+2.
- o_tx_data holds its value until the next capture.
- o_busy = 1 in S_CALC, S_TX and S_WAIT; 0 otherwise (combinational decode of the state register).
- i_rx_done in S_CALC, S_TX or S_WAIT: the byte is dropped and no register changes.
- i_tx_done is sampled only in S_WAIT; it is ignored in every other state.
- Operand and opcode registers hold their values after transmission until overwritten by the next sequence.
- Reset mid-sequence (any state): partial operands are discarded (registers cleared), the FSM returns to S_A, and no o_tx_start is issued.
- All arithmetic is performed in the ALU; this block does no width conversion beyond truncating the opcode byte.

Optional Feature:
- Macro: ALUIF_OPCHECK_EN.
- Defined: in S_OP, a received opcode that is not one of 100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111 is rejected:
  - o_op_error pulses high for one cycle (the cycle after i_rx_done).
  - o_alu_op keeps its previous value.
  - The FSM returns to S_A with no S_CALC and no o_tx_start.
  - A and B remain loaded but are overwritten by the next sequence.
- Undefined: every opcode is accepted; undefined codes produce the ALU default result 0x00, which is transmitted normally. o_op_error is tied to 0.

Test Plan:
- ALU block connected. Reset, then bytes 0x05, 0x03, 0x20 -> A=0x05, B=0x03, op=6'b100000; single-cycle o_tx_start two cycles after the op-byte i_rx_done, with o_tx_data=0x08; o_busy high until i_tx_done.
- Bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE. Then 0x80, 0x02, 0x03 (SRA) -> 0xE0. Then 0x80, 0x02, 0x02 (SRL) -> 0x20.
- After op byte 0x20, pulse i_rx_done with 0x77 while in S_WAIT -> no register change. After i_tx_done, send 0x01, 0x01, 0x20 -> o_tx_data=0x02 and A=0x01 (not 0x77).
- Send 0x11, then 0x22; assert i_reset one cycle -> all outputs 0, o_busy=0. Then 0x0F, 0xF0, 0x25 -> o_tx_data=0xFF.
- Send 0x0A, 0x0B, 0x3F:
  - Macro undefined: o_tx_data=0x00 is transmitted.
  - ALUIF_OPCHECK_EN defined: one-cycle o_op_error pulse, no o_tx_start, o_alu_op unchanged, FSM back in S_A.
- Assert i_reset and i_rx_done in the same cycle in S_A -> A stays 0x00 and the state stays S_A.
